signed_sseg_driver: RTL and testbench

- Display-side partner of the signed adder/subtractor datapath.
- Accepts the result as sign-magnitude (magnitude, sign bit, validity flag) and converts the magnitude to BCD with a sequential double-dabble engine.
- Drives the 4-digit multiplexed seven-segment display on the board: active-low anodes, active-low segments.
- Replaces a combinational display path with a registered, glitch-free scan driver.

---
 rtl/sseg_pkg.sv | 21 ++
 rtl/glyph_to_seg.sv | 26 ++
 rtl/signed_sseg_driver.sv | 85 ++++++++
 tb/tb_signed_sseg_driver.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: glyph, digit-index and FSM types plus active-low {g..a} segment codes
package sseg_pkg;
   typedef enum logic [3:0] {G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
                             G_DASH, G_BLANK, G_E, G_R} glyph_t;
   typedef logic [1:0] idx_t;
   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;
endpackage

// File: rtl/glyph_to_seg.sv
// glyph_to_seg: combinational glyph to active-low {g..a} lookup
module glyph_to_seg
   import sseg_pkg::*;
(
   input  glyph_t     g,
   output logic [6:0] code
);
   always_comb begin
      case (g)
         G_0:     code = SEG_0;
         G_1:     code = SEG_1;
         G_2:     code = SEG_2;
         G_3:     code = SEG_3;
         G_4:     code = SEG_4;
         G_5:     code = SEG_5;
         G_6:     code = SEG_6;
         G_7:     code = SEG_7;
         G_8:     code = SEG_8;
         G_9:     code = SEG_9;
         G_DASH:  code = SEG_DASH;
         G_E:     code = SEG_E;
         G_R:     code = SEG_R;
         default: code = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/signed_sseg_driver.sv
// signed_sseg_driver: sign-magnitude result to BCD via serial double-dabble,
// shown on a registered 4-digit multiplexed seven-segment scan
module signed_sseg_driver
   import sseg_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int MAG_W    = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [MAG_W-1:0] mag,
   input  logic             sign,
   input  logic             valid,
   output logic [3:0]       an,
   output logic [7:0]       seg
);
   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(MAG_W + 1);
   logic [PW-1:0]    pre;
   idx_t             idx, nidx;
   glyph_t           disp [4];
   state_t           state;
   logic             pending;
   logic [MAG_W+1:0] snap;
   logic [7:0]       bcd, adj;
   logic [MAG_W-1:0] sh;
   logic [CW-1:0]    cnt;
   logic [6:0]       code;
   logic             s_valid, s_sign, s_zero;
   assign nidx    = idx + 2'd1;
   assign adj     = {(bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4],
                     (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0]};
   assign s_valid = snap[MAG_W+1];
   assign s_sign  = snap[MAG_W];
   assign s_zero  = snap[MAG_W-1:0] == '0;
   // lookup sits on the next-digit path so an and seg register on the same edge
   glyph_to_seg u_glyph (.g(disp[nidx]), .code(code));
   always_ff @(posedge CLK) begin
      if (RST) begin
         an      <= 4'b1111;
         seg     <= 8'hFF;
         pre     <= '0;
         idx     <= '0;
         disp    <= '{default: G_BLANK};
         state   <= IDLE;
         pending <= 1'b1;
         snap    <= '0;
         bcd     <= '0;
         sh      <= '0;
         cnt     <= '0;
      end else begin
         if (pre == PW'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= nidx;
            an  <= ~(4'b0001 << nidx);
            seg <= {1'b1, code};
         end else begin
            pre <= pre + 1'b1;
         end
         case (state)
            IDLE: if (pending || {valid, sign, mag} != snap) begin
               snap    <= {valid, sign, mag};
               pending <= 1'b0;
               bcd     <= '0;
               sh      <= mag;
               cnt     <= '0;
               state   <= CONV;
            end
            CONV: begin
               {bcd, sh} <= {adj, sh} << 1;
               cnt       <= cnt + 1'b1;
               if (cnt == CW'(MAG_W - 1)) state <= LOAD;
            end
            LOAD: begin
               disp[3] <= s_valid ? G_BLANK : G_E;
               disp[2] <= !s_valid ? G_R : (s_sign && !s_zero) ? G_DASH : G_BLANK;
               disp[1] <= !s_valid ? G_R : (bcd[7:4] == 4'd0) ? G_BLANK : glyph_t'(bcd[7:4]);
               disp[0] <= !s_valid ? G_BLANK : glyph_t'(bcd[3:0]);
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_signed_sseg_driver.sv
// tb_signed_sseg_driver: directed checks of conversion, scan timing and reset
module tb_signed_sseg_driver;
   import sseg_pkg::*;
   logic       CLK = 1'b0, RST = 1'b1;
   logic [4:0] mag = 5'd0;
   logic       sign = 1'b0, valid = 1'b1;
   logic [3:0] an;
   logic [7:0] seg;
   int         checks = 0, errors = 0;

   signed_sseg_driver #(.SCAN_DIV(4), .MAG_W(5)) dut (
      .CLK(CLK), .RST(RST), .mag(mag), .sign(sign), .valid(valid), .an(an), .seg(seg));

   always #5 CLK = ~CLK;

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_disp(input string tag, input glyph_t d3, d2, d1, d0);
      chk(tag, {16'd0, dut.disp[3], dut.disp[2], dut.disp[1], dut.disp[0]}, {16'd0, d3, d2, d1, d0});
   endtask

   task automatic wait_an(input logic [3:0] t);
      for (int i = 0; i < 40 && an !== t; i++) step(1);
   endtask

   // one full scan rotation starting at the first anode pattern, each digit held 4 cycles
   task automatic scan4(input string tag, input logic [15:0] a, input logic [31:0] s);
      wait_an(a[15:12]);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_an"}, an, a[15-4*i -: 4]);
         chk({tag, "_seg"}, seg, s[31-8*i -: 8]);
         step(3);
         chk({tag, "_hold"}, an, a[15-4*i -: 4]);
         step(1);
      end
   endtask

   initial begin
      step(3);
      chk("rst_an", an, 4'b1111);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_state", dut.state, IDLE);
      RST = 1'b0;
      step(3);
      chk("pre_tc_an", an, 4'b1111);
      chk("pre_tc_seg", seg, 8'hFF);
      step(1);
      chk("first_tc_an", an, 4'b1101);
      step(2);
      chk_disp("rst_disp_early", G_BLANK, G_BLANK, G_BLANK, G_BLANK);
      step(1);
      chk_disp("rst_disp", G_BLANK, G_BLANK, G_BLANK, G_0);

      mag = 5'd13; sign = 1'b1;
      step(8);
      chk_disp("neg13_disp", G_BLANK, G_DASH, G_1, G_3);
      scan4("neg13", 16'b1110_1101_1011_0111, 32'hB0_F9_BF_FF);

      valid = 1'b0; mag = 5'd9;
      step(8);
      chk_disp("err_disp", G_E, G_R, G_R, G_BLANK);
      scan4("err", 16'b1110_1101_1011_0111, 32'hFF_AF_AF_86);

      valid = 1'b1; sign = 1'b0; mag = 5'd7;
      step(2);
      chk("conv2_state", dut.state, CONV);
      mag = 5'd22;
      step(5);
      chk_disp("first_load", G_BLANK, G_BLANK, G_BLANK, G_7);
      step(6);
      chk_disp("before_second", G_BLANK, G_BLANK, G_BLANK, G_7);
      step(1);
      chk_disp("second_load", G_BLANK, G_BLANK, G_2, G_2);

      mag = 5'd16; sign = 1'b1;
      step(8);
      chk_disp("neg16", G_BLANK, G_DASH, G_1, G_6);
      mag = 5'd0;
      step(8);
      chk_disp("neg_zero", G_BLANK, G_BLANK, G_BLANK, G_0);
      mag = 5'd31; sign = 1'b0;
      step(8);
      chk_disp("pos31", G_BLANK, G_BLANK, G_3, G_1);
      mag = 5'd10;
      step(8);
      chk_disp("pos10", G_BLANK, G_BLANK, G_1, G_0);

      for (int i = 0; i < 40 && dut.idx != 2'd2; i++) step(1);
      chk("idx_is_2", dut.idx, 2'd2);
      mag = 5'd3;
      step(1);
      chk("mid_conv_state", dut.state, CONV);
      chk("mid_conv_idx", dut.idx, 2'd2);
      RST = 1'b1;
      step(1);
      chk("midrst_an", an, 4'b1111);
      chk("midrst_seg", seg, 8'hFF);
      chk("midrst_state", dut.state, IDLE);
      chk("midrst_idx", dut.idx, 2'd0);
      RST = 1'b0;
      step(1);
      chk("post_rst_state", dut.state, CONV);
      chk("post_rst_an", an, 4'b1111);
      step(2);
      chk("post_rst_an3", an, 4'b1111);
      step(1);
      chk("post_rst_tc_an", an, 4'b1101);
      chk("post_rst_tc_seg", seg, 8'hFF);
      step(3);
      chk_disp("post_rst_disp", G_BLANK, G_BLANK, G_BLANK, G_3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
